// File: rtl/rca_result_display.sv
// rca_result_display
// Captures the sum from the pipelined ripple-carry adder once it has settled,
// converts it to two BCD digits with a sequential double-dabble and drives a
// two-digit multiplexed, active-low 7-segment display.
module rca_result_display #(
    parameter int LATENCY   = 5,
    parameter int REFRESH_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] Y,
    output logic       busy,
    output logic       done,
    output logic [4:0] result,
    output logic [6:0] seg,
    output logic [1:0] an
);

    typedef enum logic [1:0] {IDLE, WAIT, CONV, SHOW} state_t;

    state_t               state;
    logic [3:0]           lat_cnt;
    logic [2:0]           iter;
    logic [4:0]           bin;
    logic [4:0]           y_cap;
    logic [7:0]           bcd;
    logic [3:0]           tens;
    logic [3:0]           ones;
    logic                 shown;
    logic [REFRESH_W-1:0] refresh;

    logic [7:0]           bcd_adj;
    logic [7:0]           bcd_next;
    logic [4:0]           bin_next;

    // Active-low digit decode; anything outside 0..9 shows a dark digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // One double-dabble step: correct both nibbles, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        {bcd_next, bin_next} = {bcd_adj[6:0], bin, 1'b0};
    end

    // Control FSM: wait out the adder latency, capture, convert, publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 5'd0;
            lat_cnt <= 4'd0;
            iter    <= 3'd0;
            bin     <= 5'd0;
            y_cap   <= 5'd0;
            bcd     <= 8'd0;
            tens    <= 4'd0;
            ones    <= 4'd0;
            shown   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, SHOW: begin
                    if (start) begin
                        state   <= WAIT;
                        busy    <= 1'b1;
                        lat_cnt <= 4'd1;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'(LATENCY)) begin
                        bin   <= Y;
                        y_cap <= Y;
                        bcd   <= 8'd0;
                        iter  <= 3'd0;
                        state <= CONV;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                CONV: begin
                    bin  <= bin_next;
                    bcd  <= bcd_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd4) begin
                        tens   <= bcd_next[7:4];
                        ones   <= bcd_next[3:0];
                        result <= y_cap;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        shown  <= 1'b1;
                        state  <= SHOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running refresh counter and registered digit multiplexing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh <= '0;
            seg     <= 7'h7F;
            an      <= 2'b11;
        end else begin
            refresh <= refresh + {{(REFRESH_W-1){1'b0}}, 1'b1};
            if (!shown) begin
                seg <= 7'h7F;
                an  <= 2'b11;
            end else if (!refresh[REFRESH_W-1]) begin
                seg <= seg_decode(ones);
                an  <= 2'b10;
            end else if (tens == 4'd0) begin
                seg <= 7'h7F;
                an  <= 2'b11;
            end else begin
                seg <= seg_decode(tens);
                an  <= 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_rca_result_display.sv
// tb_rca_result_display
// Directed vectors with a result/timing scoreboard popped on every done pulse,
// plus direct checks of the multiplexed display in each digit slot.
module tb_rca_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] y_in = 5'd0;
    logic       busy;
    logic       done;
    logic [4:0] result;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [3:0] tb_refresh;

    typedef struct {
        int res;
        int cycle;
    } exp_t;

    exp_t exp_q[$];

    rca_result_display #(.LATENCY(5), .REFRESH_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .Y(y_in),
        .busy(busy),
        .done(done),
        .result(result),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to check start-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference refresh counter used to pick the middle of each digit slot.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_refresh <= 4'd0;
        else      tb_refresh <= tb_refresh + 4'd1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding launch.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("result", int'(result), e.res);
                checkOutput("done_cycle", cyc, e.cycle);
                checkOutput("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Launch one operand: start high for the next edge (E0), done due at E0+10.
    task automatic applyStimulus(input logic [4:0] v);
        exp_t e;
        y_in  = v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e.res   = int'(v);
        e.cycle = cyc + 10;
        exp_q.push_back(e);
    endtask

    task automatic waitDone();
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic checkDisplay(input int ones_seg, input int tens_an, input int tens_seg);
        bit found;
        repeat (2) @(negedge clk);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (tb_refresh == 4'd4) begin found = 1; break; end
            @(negedge clk);
        end
        if (!found) checkOutput("ones_slot_timeout", 0, 1);
        checkOutput("ones_an", int'(an), 2);
        checkOutput("ones_seg", int'(seg), ones_seg);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (tb_refresh == 4'd12) begin found = 1; break; end
            @(negedge clk);
        end
        if (!found) checkOutput("tens_slot_timeout", 0, 1);
        checkOutput("tens_an", int'(an), tens_an);
        checkOutput("tens_seg", int'(seg), tens_seg);
    endtask

    initial begin
        // Reset held low while start pulses.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 start = ~start;
            y_in = 5'd23;
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_an", int'(an), 3);
        checkOutput("rst_seg", int'(seg), 'h7F);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("dark_an", int'(an), 3);
        checkOutput("dark_seg", int'(seg), 'h7F);
        checkOutput("idle_busy", int'(busy), 0);

        $display("[TB] Y=23");
        @(posedge clk); #1;
        applyStimulus(5'd23);
        checkOutput("busy_after_start", int'(busy), 1);
        waitDone();
        checkDisplay('h30, 1, 'h24);

        $display("[TB] Y=31");
        applyStimulus(5'd31);
        waitDone();
        checkDisplay('h79, 1, 'h30);

        $display("[TB] Y=0");
        applyStimulus(5'd0);
        waitDone();
        checkDisplay('h40, 3, 'h7F);

        $display("[TB] Y=7");
        applyStimulus(5'd7);
        waitDone();
        checkDisplay('h78, 3, 'h7F);

        $display("[TB] start during WAIT ignored");
        applyStimulus(5'd12);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone();
        checkDisplay('h24, 1, 'h79);

        $display("[TB] start in done cycle accepted");
        applyStimulus(5'd9);
        waitDone();
        applyStimulus(5'd18);
        waitDone();
        checkDisplay('h00, 1, 'h79);

        $display("[TB] reset during CONV");
        applyStimulus(5'd20);
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_result", int'(result), 0);
        checkOutput("midrst_an", int'(an), 3);
        checkOutput("midrst_seg", int'(seg), 'h7F);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_rst_an", int'(an), 3);
        checkOutput("post_rst_seg", int'(seg), 'h7F);
        checkOutput("post_rst_result", int'(result), 0);
        checkOutput("post_rst_busy", int'(busy), 0);

        checkOutput("pending_results", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_result_display.md
Name: rca_result_display

Overview:
Downstream consumer of the 4-bit pipelined ripple-carry adder stage. It waits out the adder's settle latency after each operand launch and captures the 5-bit sum. It converts the sum to two BCD digits with a sequential double-dabble and drives a 2-digit multiplexed 7-segment display on the lab board.

Parameters:
LATENCY, 5, clock edges from the operand-launch edge to the edge at which the adder's sum output is valid and captured (range 1..15).
REFRESH_W, 16, width of the display refresh counter; its MSB selects the active digit.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; the upstream adder's operands are applied in this cycle and held stable for LATENCY cycles.
Y  input  5  sum output of the adder stage (0..31).
busy  output  1  high while a capture/conversion is in progress.
done  output  1  one-cycle pulse when result and digits update.
result  output  5  last captured sum.
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
an  output  2  digit enables, active-low; an[1]=tens, an[0]=ones.

Behaviour:
- Reset (rst low, async): state IDLE; busy=0, done=0, result=0, BCD digit regs=0, refresh counter=0, seg=7'h7F, an=2'b11 (display dark). A "shown" flag clears and stays 0 until the first done.
- FSM states: IDLE, WAIT, CONV, SHOW.
- IDLE/SHOW + start=1 at edge E0 -> WAIT; busy=1 from E0. The latency counter loads 1.
- WAIT: the counter increments each edge. At edge E0+LATENCY, Y is latched into the internal shift register (bin=Y, bcd=8'h00), iteration count=0, and the FSM goes to CONV.
- CONV: one double-dabble iteration per edge, 5 iterations (edges E0+LATENCY+1 .. +5).
  - Each iteration: for each BCD nibble >= 5, add 3, then shift {bcd,bin} left 1.
  - Both nibbles are corrected even though tens never exceeds 3.
  - On the 5th iteration edge: tens/ones regs and result are loaded (result = captured Y), done=1 for exactly one cycle, busy=0, shown=1, and the FSM goes to SHOW.
- Total start->done: LATENCY+5 cycles (10 at default). A new start is accepted in the cycle done is high.
- start while busy=1 is ignored; no queuing.
- Reset mid-WAIT/CONV: immediate return to reset values; the partial result is discarded.
- Display: the refresh counter free-runs from reset.
  - MSB=0 selects ones (an=2'b10); MSB=1 selects tens (an=2'b01).
  - Digit decode is active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Leading-zero blanking: when tens==0, an[1] stays 1 during the tens slot and seg=7'h7F.
  - While shown=0, an=2'b11 and seg=7'h7F in all slots.
- During a new conversion the previous digits remain displayed until done.
- seg and an are registered outputs (one cycle after counter/digit change).

Test Plan:
- Reset: hold rst=0 mid-count with start pulsing -> busy=0, done=0, result=0, an=2'b11, seg=7'h7F; after release the display stays dark with no start.
- Y=23 held, start pulse at E0 -> done high exactly at E0+10, result=23. Ones slot: an=2'b10, seg=7'h30. Tens slot: an=2'b01, seg=7'h24.
- Y=31 -> result=31, digits 3/1 (seg 7'h30 in tens slot, 7'h79 in ones slot). Y=0 -> ones seg=7'h40, tens slot blank (an=2'b11).
- Y=7 -> tens slot blanked (an=2'b11, seg=7'h7F), ones seg=7'h78.
- A second start at E0+3 (during WAIT) -> ignored; done at E0+10 only. A start in the done cycle -> accepted, next done 10 cycles later.
- rst pulsed low at E0+7 (during CONV) -> no done pulse; outputs return to reset values and the display goes dark.
